// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter: round-robin arbiter sharing one AHB address/data path.
// Grant moves only at address-phase boundaries, never inside bursts or locks.
package ahb_rr_pkg;
    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;
endpackage

module ahb_rr_arbiter
    import ahb_rr_pkg::*;
#(
    parameter int ReqNum  = 4,
    parameter int IdWidth = $clog2(ReqNum)
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic [ReqNum-1:0]  req,
    input  logic [ReqNum-1:0]  lock,
    input  logic [1:0]         trans,
    input  logic               ready,
    output logic [ReqNum-1:0]  grant,
    output logic [IdWidth-1:0] owner,
    output logic [IdWidth-1:0] data_owner,
    output logic               data_valid
);

    htrans_e            tr;
    logic               hold;
    logic               found;
    logic [IdWidth-1:0] pick;
    logic [IdWidth-1:0] nxt_owner;
    logic [ReqNum-1:0]  nxt_grant;
    logic               nxt_valid;

    assign tr = htrans_e'(trans);

    always_comb begin
        hold = 1'b0;
        unique case (tr)
            TR_SEQ, TR_BUSY: hold = 1'b1;
            TR_NONSEQ:       hold = req[owner];
            default:         hold = 1'b0;
        endcase
        if (lock[owner]) begin
            hold = 1'b1;
        end
    end

    // Scan starts one past the owner so the owner is considered last.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = owner;
        idx   = 0;
        for (int i = 1; i <= ReqNum; i++) begin
            idx = (int'(owner) + i) % ReqNum;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IdWidth'(idx);
            end
        end
    end

    always_comb begin
        nxt_owner = owner;
        if (!hold && found) begin
            nxt_owner = pick;
        end
        nxt_grant = {{(ReqNum-1){1'b0}}, 1'b1} << nxt_owner;
        nxt_valid = (tr == TR_NONSEQ) || (tr == TR_SEQ);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            grant      <= {{(ReqNum-1){1'b0}}, 1'b1};
            owner      <= '0;
            data_owner <= '0;
            data_valid <= 1'b0;
        end else if (ready) begin
            grant      <= nxt_grant;
            owner      <= nxt_owner;
            data_owner <= owner;
            data_valid <= nxt_valid;
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter: directed checks of the round-robin AHB arbiter.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_ahb_rr_arbiter;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;

    logic       clk;
    logic       nReset;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] owner;
    logic [1:0] data_owner;
    logic       data_valid;

    int n_cmp;
    int n_bad;

    ahb_rr_arbiter #(.ReqNum(4)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .req        (req),
        .lock       (lock),
        .trans      (trans),
        .ready      (ready),
        .grant      (grant),
        .owner      (owner),
        .data_owner (data_owner),
        .data_valid (data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g,
                           input logic [1:0] o, input logic [1:0] d,
                           input logic v);
        chk({tag, ".grant"}, 8'(grant), 8'(g));
        chk({tag, ".owner"}, 8'(owner), 8'(o));
        chk({tag, ".downer"}, 8'(data_owner), 8'(d));
        chk({tag, ".dvalid"}, 8'(data_valid), 8'(v));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        nReset = 1'b0;
        req    = '0;
        lock   = '0;
        trans  = IDLE;
        ready  = 1'b1;
        #12;
        chk_all("reset", 4'b0001, 2'd0, 2'd0, 1'b0);
        cyc();
        nReset = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk_all("idle10", 4'b0001, 2'd0, 2'd0, 1'b0);

        // basic rotation and park
        req = 4'b0110;
        cyc();
        chk_all("rr_1", 4'b0010, 2'd1, 2'd0, 1'b0);
        req = 4'b0100;
        cyc();
        chk_all("rr_2", 4'b0100, 2'd2, 2'd1, 1'b0);
        req = 4'b0000;
        cyc();
        chk_all("park", 4'b0100, 2'd2, 2'd2, 1'b0);

        // 4-beat burst from owner 2 with manager 3 waiting
        req   = 4'b1100;
        trans = NONSEQ;
        cyc();
        chk_all("b_ns", 4'b0100, 2'd2, 2'd2, 1'b1);
        trans = SEQ;
        cyc();
        chk("b_seq1", 8'(grant), 8'h04);
        req = 4'b1000;
        cyc();
        chk("b_seq2", 8'(grant), 8'h04);
        cyc();
        chk_all("b_last", 4'b0100, 2'd2, 2'd2, 1'b1);
        trans = IDLE;
        cyc();
        chk_all("b_end", 4'b1000, 2'd3, 2'd2, 1'b0);

        // lock by owner 1
        req = 4'b0010;
        cyc();
        chk("to1", 8'(grant), 8'h02);
        lock = 4'b0010;
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("lock%0d", i), 8'(grant), 8'h02);
        end
        lock = 4'b0000;
        cyc();
        chk_all("unlock", 4'b0100, 2'd2, 2'd1, 1'b0);

        // stall freezes everything
        req   = 4'b0100;
        trans = NONSEQ;
        cyc();
        chk_all("pre_stall", 4'b0100, 2'd2, 2'd2, 1'b1);
        trans = IDLE;
        ready = 1'b0;
        req   = 4'b0001;
        cyc();
        chk_all("stall1", 4'b0100, 2'd2, 2'd2, 1'b1);
        req = 4'b0010;
        cyc();
        chk_all("stall2", 4'b0100, 2'd2, 2'd2, 1'b1);
        req = 4'b1000;
        cyc();
        chk_all("stall3", 4'b0100, 2'd2, 2'd2, 1'b1);
        ready = 1'b1;
        cyc();
        chk_all("unstall", 4'b1000, 2'd3, 2'd2, 1'b0);

        // async reset mid-burst
        trans = SEQ;
        cyc();
        chk_all("mid_burst", 4'b1000, 2'd3, 2'd3, 1'b1);
        #2;
        nReset = 1'b0;
        #1;
        chk_all("async_rst", 4'b0001, 2'd0, 2'd0, 1'b0);
        cyc();
        chk_all("rst_hold", 4'b0001, 2'd0, 2'd0, 1'b0);
        nReset = 1'b1;
        trans  = IDLE;
        req    = 4'b0000;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
